// File: rtl/alu_result_streamer_if.sv
// Byte stream carrying framed alu results from the streamer to the host bridge.
// The master drives data/valid/last; the slave answers with ready.
interface alu_result_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/alu_result_streamer.sv
// Captures an alu result on the rising edge of done and streams it as a
// header byte followed by the matrix (or determinant) payload.
module alu_result_streamer #(
  parameter int MAX_N = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     done,
  input  logic [2:0]               opcode,
  input  logic [2:0]               matrix_size,
  input  logic [MAX_N*MAX_N*8-1:0] C_flat,
  input  logic [7:0]               number,
  input  logic                     overflow_flag,
  alu_result_streamer_if.master    stream,
  output logic                     busy,
  output logic                     missed
);

  localparam int NUM_ELEMS = MAX_N * MAX_N;
  localparam int IDX_W     = $clog2(NUM_ELEMS);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t           state;
  logic             done_q;
  logic [2:0]       row;
  logic [2:0]       col;

  logic [2:0]       sh_op;
  logic [2:0]       sh_n;
  logic [7:0]       sh_num;
  logic [7:0]       sh_elem [NUM_ELEMS];

  logic             done_rise;
  logic             capture;
  logic [2:0]       n_eff_in;
  logic [2:0]       next_row;
  logic [2:0]       next_col;
  logic [IDX_W-1:0] next_idx;
  logic             next_last;

  assign done_rise = done & ~done_q;
  assign capture   = (state == IDLE) && done_rise && (opcode != 3'b000);
  assign n_eff_in  = (matrix_size >= 3'd2 && matrix_size <= 3'(MAX_N)) ? matrix_size : 3'(MAX_N);

  // Position of the element that follows the one currently presented.
  always_comb begin
    next_row = row;
    next_col = col + 3'd1;
    if (col == sh_n - 3'd1) begin
      next_col = 3'd0;
      next_row = row + 3'd1;
    end
    next_idx  = IDX_W'(next_row) * IDX_W'(MAX_N) + IDX_W'(next_col);
    next_last = (next_row == sh_n - 3'd1) && (next_col == sh_n - 3'd1);
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      sh_op  <= opcode;
      sh_n   <= n_eff_in;
      sh_num <= number;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        sh_elem[i] <= C_flat[i*8 +: 8];
      end
    end
  end

  // out_valid is high in HEADER and PAYLOAD, so out_ready alone marks a transfer there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      done_q           <= 1'b1;
      row              <= 3'd0;
      col              <= 3'd0;
      stream.out_data  <= 8'd0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      missed           <= 1'b0;
    end else begin
      done_q <= done;
      missed <= done_rise && (state != IDLE);
      case (state)
        IDLE: begin
          if (capture) begin
            state            <= HEADER;
            stream.out_data  <= {opcode, n_eff_in, overflow_flag, 1'b0};
            stream.out_valid <= 1'b1;
            stream.out_last  <= 1'b0;
            busy             <= 1'b1;
          end
        end
        HEADER: begin
          if (stream.out_ready) begin
            state           <= PAYLOAD;
            row             <= 3'd0;
            col             <= 3'd0;
            stream.out_data <= (sh_op == 3'b111) ? sh_num : sh_elem[0];
            stream.out_last <= (sh_op == 3'b111);
          end
        end
        PAYLOAD: begin
          if (stream.out_ready) begin
            if (stream.out_last) begin
              state            <= IDLE;
              stream.out_data  <= 8'd0;
              stream.out_valid <= 1'b0;
              stream.out_last  <= 1'b0;
              busy             <= 1'b0;
            end else begin
              row             <= next_row;
              col             <= next_col;
              stream.out_data <= sh_elem[next_idx];
              stream.out_last <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_streamer.sv
// Randomized and directed bench for alu_result_streamer, checked against a
// frame-queue model of the expected byte stream.
module tb_alu_result_streamer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         done = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [2:0]   matrix_size = 3'd0;
  logic [199:0] C_flat = '0;
  logic [7:0]   number = 8'd0;
  logic         overflow_flag = 1'b0;
  logic         busy;
  logic         missed;

  int compared = 0;
  int mismatched = 0;
  int missed_seen = 0;
  int ready_mode = 0;

  beat_t      exp_q[$];
  beat_t      log_q[$];
  logic [7:0] ref_bytes[$];

  alu_result_streamer_if stream_if();

  alu_result_streamer #(.MAX_N(5)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .done          (done),
    .opcode        (opcode),
    .matrix_size   (matrix_size),
    .C_flat        (C_flat),
    .number        (number),
    .overflow_flag (overflow_flag),
    .stream        (stream_if),
    .busy          (busy),
    .missed        (missed)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the whole frame is built as a list of bytes at capture time.
  task automatic model_capture();
    int    n;
    beat_t b;
    n = (matrix_size >= 2 && matrix_size <= 5) ? int'(matrix_size) : 5;
    b.data = {opcode, 3'(n), overflow_flag, 1'b0};
    b.last = 1'b0;
    exp_q.push_back(b);
    if (opcode == 3'b111) begin
      b.data = number;
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          b.data = C_flat[(r*5+c)*8 +: 8];
          b.last = (r == n-1) && (c == n-1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  initial begin
    logic  done_prev;
    logic  exp_missed;
    logic  busy_before;
    beat_t seen;
    done_prev  = 1'b1;
    exp_missed = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete();
        done_prev  = 1'b1;
        exp_missed = 1'b0;
      end else begin
        busy_before = (exp_q.size() != 0);
        checkOutput("missed", 32'(missed), 32'(exp_missed));
        if (missed) missed_seen++;
        checkOutput("busy", 32'(busy), 32'(busy_before));
        checkOutput("out_valid", 32'(stream_if.out_valid), 32'(busy_before));
        if (busy_before) begin
          checkOutput("out_data", 32'(stream_if.out_data), 32'(exp_q[0].data));
          checkOutput("out_last", 32'(stream_if.out_last), 32'(exp_q[0].last));
          if (stream_if.out_ready) begin
            seen.data = stream_if.out_data;
            seen.last = stream_if.out_last;
            log_q.push_back(seen);
            void'(exp_q.pop_front());
          end
        end
        exp_missed = 1'b0;
        if (done && !done_prev) begin
          if (busy_before) exp_missed = 1'b1;
          else if (opcode != 3'b000) model_capture();
        end
        done_prev = done;
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    stream_if.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       stream_if.out_ready = 1'b1;
        1:       stream_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: stream_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] size,
                               input logic [199:0] c, input logic [7:0] num, input logic ovf);
    @(posedge clock);
    #1;
    opcode        = op;
    matrix_size   = size;
    C_flat        = c;
    number        = num;
    overflow_flag = ovf;
    done          = 1'b1;
    @(posedge clock);
    #1;
    done = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int n);
    int k;
    k = 0;
    while (log_q.size() < n && k < 300) begin
      @(posedge clock);
      k++;
    end
    checkOutput(tag, 32'(log_q.size()), 32'(n));
  endtask

  task automatic check_log(input string tag);
    for (int i = 0; i < ref_bytes.size() && i < log_q.size(); i++) begin
      checkOutput({tag, "_data"}, 32'(log_q[i].data), 32'(ref_bytes[i]));
      checkOutput({tag, "_last"}, 32'(log_q[i].last), 32'(i == ref_bytes.size() - 1));
    end
  endtask

  initial begin
    logic [199:0] c;
    int           missed0;
    int           k;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(stream_if.out_valid), 32'd0);
    checkOutput("rst_data", 32'(stream_if.out_data), 32'd0);
    checkOutput("rst_last", 32'(stream_if.out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_missed", 32'(missed), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    c = '0;
    c[7:0] = 8'h01; c[15:8] = 8'h02; c[47:40] = 8'h03; c[55:48] = 8'h04;
    log_q.delete();
    applyStimulus(3'b001, 3'd2, c, 8'h00, 1'b0);
    wait_frame("sum_len", 5);
    ref_bytes = '{8'h28, 8'h01, 8'h02, 8'h03, 8'h04};
    check_log("sum");
    repeat (2) @(posedge clock);

    log_q.delete();
    applyStimulus(3'b111, 3'd3, c, 8'hFA, 1'b1);
    wait_frame("det_len", 2);
    #1;
    checkOutput("det_busy_after", 32'(busy), 32'd0);
    ref_bytes = '{8'hEE, 8'hFA};
    check_log("det");
    repeat (2) @(posedge clock);

    for (int i = 0; i < 25; i++) c[i*8 +: 8] = 8'(i);
    log_q.delete();
    applyStimulus(3'b011, 3'd0, c, 8'h00, 1'b0);
    wait_frame("clamp_len", 26);
    ref_bytes.delete();
    ref_bytes.push_back(8'h74);
    for (int i = 0; i < 25; i++) ref_bytes.push_back(8'(i));
    check_log("clamp");
    repeat (2) @(posedge clock);

    for (int i = 0; i < 25; i++) c[i*8 +: 8] = 8'($urandom);
    ready_mode = 1;
    log_q.delete();
    applyStimulus(3'b010, 3'd2, c, 8'h00, 1'b0);
    for (int i = 0; i < 25; i++) C_flat[i*8 +: 8] = ~c[i*8 +: 8];
    number      = 8'($urandom);
    matrix_size = 3'd4;
    opcode      = 3'b111;
    wait_frame("bp_len", 5);
    ref_bytes = '{8'h48, c[7:0], c[15:8], c[47:40], c[55:48]};
    check_log("bp");
    ready_mode = 0;
    repeat (3) @(posedge clock);

    missed0 = missed_seen;
    applyStimulus(3'b001, 3'd3, c, 8'h00, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    done = 1'b1;
    @(posedge clock);
    #1;
    done = 1'b0;
    k = 0;
    while (k < 100) begin
      @(posedge clock);
      #1;
      k++;
      if (exp_q.size() == 1) break;
    end
    done = 1'b1;
    @(posedge clock);
    #1;
    done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("overlap_missed", 32'(missed_seen - missed0), 32'd2);

    applyStimulus(3'b001, 3'd5, c, 8'h00, 1'b0);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(stream_if.out_valid), 32'd0);
    checkOutput("abort_data", 32'(stream_if.out_data), 32'd0);
    checkOutput("abort_last", 32'(stream_if.out_last), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("release_done_high", 32'(busy), 32'd0);
    done = 1'b0;
    @(posedge clock);
    missed0 = missed_seen;
    applyStimulus(3'b000, 3'd2, c, 8'h00, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("noop_busy", 32'(busy), 32'd0);
    checkOutput("noop_missed", 32'(missed_seen - missed0), 32'd0);

    ready_mode = 2;
    for (int cy = 0; cy < 3000; cy++) begin
      @(posedge clock);
      #1;
      if ($urandom_range(0, 5) == 0) done = ~done;
      opcode        = 3'($urandom);
      matrix_size   = 3'($urandom);
      number        = 8'($urandom);
      overflow_flag = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 25; i++) C_flat[i*8 +: 8] = 8'($urandom);
      end
    end
    done       = 1'b0;
    ready_mode = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clock);
      k++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
